// File: rtl/fx1_simd_add_if.sv
// Handshake bus of fx1_simd_add: the operation request channel and the result channel.
// Operand/result vectors use ascending bit order; element 0 sits in the lowest-numbered bits.
interface fx1_simd_add_if #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 7
);
    logic                 in_valid;
    logic                 in_ready;
    logic [0:DATA_W-1]    ra;
    logic [0:DATA_W-1]    rb;
    logic [2:0]           op;
    logic [TAG_W-1:0]     tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:DATA_W-1]    result;
    logic [TAG_W-1:0]     tag_out;
    logic [0:DATA_W/16-1] ovf;

    modport master (
        output in_valid, ra, rb, op, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out, ovf
    );

    modport slave (
        input  in_valid, ra, rb, op, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out, ovf
    );
endinterface

// File: rtl/fx1_simd_add.sv
// Pipelined SIMD add/subtract-from over 16-bit or 32-bit lanes with per-halfword signed-overflow flags.
// Define FX1_SAT_EN to build the signed saturation selected by op[2]; otherwise results always wrap.
module fx1_simd_add #(
    parameter int DATA_W = 128,
    parameter int STAGES = 2,
    parameter int TAG_W  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    fx1_simd_add_if.slave bus
);
    localparam int NH = DATA_W / 16;
    localparam int NW = DATA_W / 32;

    typedef struct packed {
        logic              valid;
        logic [0:DATA_W-1] res;
        logic [TAG_W-1:0]  tag;
        logic [0:NH-1]     ovf;
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    logic [0:DATA_W-1] calc_res;
    logic [0:NH-1]     calc_ovf;
    logic              adv;

    // Returns {overflow, wrapped sum}; sub selects b - a.
    function automatic logic [16:0] lane16(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] s;
        logic        o;
        s = sub ? (b - a) : (a + b);
        o = sub ? ((a[15] != b[15]) && (s[15] != b[15]))
                : ((a[15] == b[15]) && (s[15] != a[15]));
        return {o, s};
    endfunction

    function automatic logic [32:0] lane32(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] s;
        logic        o;
        s = sub ? (b - a) : (a + b);
        o = sub ? ((a[31] != b[31]) && (s[31] != b[31]))
                : ((a[31] == b[31]) && (s[31] != a[31]));
        return {o, s};
    endfunction

`ifndef FX1_SAT_EN
    logic unused_op2;
    assign unused_op2 = bus.op[2];
`endif

    always_comb begin
        logic [16:0] hw_r;
        logic [32:0] wd_r;
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        hw_r     = '0;
        wd_r     = '0;
        calc_res = '0;
        calc_ovf = '0;
        if (bus.op[0]) begin
            for (int i = 0; i < NW; i++) begin
                wd_r = lane32(bus.ra[32*i +: 32], bus.rb[32*i +: 32], bus.op[1]);
`ifdef FX1_SAT_EN
                // On overflow the wrapped sign is the inverse of the true sign.
                if (bus.op[2] && wd_r[32]) wd_r[31:0] = wd_r[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
                calc_res[32*i +: 32] = wd_r[31:0];
                calc_ovf[2*i]        = wd_r[32];
                calc_ovf[2*i+1]      = wd_r[32];
            end
        end else begin
            for (int i = 0; i < NH; i++) begin
                hw_r = lane16(bus.ra[16*i +: 16], bus.rb[16*i +: 16], bus.op[1]);
`ifdef FX1_SAT_EN
                if (bus.op[2] && hw_r[16]) hw_r[15:0] = hw_r[15] ? 16'h7FFF : 16'h8000;
`endif
                calc_res[16*i +: 16] = hw_r[15:0];
                calc_ovf[i]          = hw_r[16];
            end
        end
    end

    // The whole pipe moves together or holds together, bubbles included.
    assign adv = !stage_q[STAGES-1].valid || bus.out_ready;

    always_comb begin
        stage_d = stage_q;
        if (adv) begin
            stage_d[0].valid = bus.in_valid;
            stage_d[0].res   = calc_res;
            stage_d[0].tag   = bus.tag_in;
            stage_d[0].ovf   = calc_ovf;
            for (int s = 1; s < STAGES; s++) begin
                stage_d[s] = stage_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data fields are reset along with valid because outputs must read zero after reset.
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
            stage_q <= stage_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.result    = stage_q[STAGES-1].res;
    assign bus.tag_out   = stage_q[STAGES-1].tag;
    assign bus.ovf       = stage_q[STAGES-1].ovf;
endmodule

// File: tb/tb_fx1_simd_add.sv
// Self-checking bench for fx1_simd_add: lane-arithmetic reference model with scoreboard plus directed literal checks.
module tb_fx1_simd_add;
    localparam int DATA_W = 128;
    localparam int STAGES = 2;
    localparam int TAG_W  = 7;
    localparam int NH     = DATA_W / 16;

`ifdef FX1_SAT_EN
    localparam logic [15:0] SAT_HW_EXP = 16'h7FFF;
`else
    localparam logic [15:0] SAT_HW_EXP = 16'h8000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fx1_simd_add_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    fx1_simd_add #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [0:DATA_W-1] res;
        logic [TAG_W-1:0]  tag;
        logic [0:NH-1]     ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_pop   = 0;
    int   n_drop  = 0;

    logic [0:DATA_W-1] pr;
    logic [0:NH-1]     pf;
    logic [0:DATA_W-1] snap_res;
    logic [TAG_W-1:0]  snap_tag;
    logic [0:NH-1]     snap_ovf;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: true signed lane result in wide integers, then range test, clamp and truncate.
    function automatic void model(input logic [0:DATA_W-1] a, input logic [0:DATA_W-1] b,
                                  input logic [2:0] o,
                                  output logic [0:DATA_W-1] r, output logic [0:NH-1] f);
        bit     sat;
        bit     ov;
        longint sa, sb, t, hi, lo;
`ifdef FX1_SAT_EN
        sat = o[2];
`else
        sat = 1'b0;
`endif
        r = '0;
        f = '0;
        if (o[0]) begin
            hi = 2147483647;
            lo = -hi - 1;
            for (int i = 0; i < DATA_W/32; i++) begin
                sa = longint'($signed(a[32*i +: 32]));
                sb = longint'($signed(b[32*i +: 32]));
                t  = o[1] ? (sb - sa) : (sa + sb);
                ov = (t > hi) || (t < lo);
                if (sat && ov) t = (t > hi) ? hi : lo;
                r[32*i +: 32] = t[31:0];
                f[2*i]        = ov;
                f[2*i+1]      = ov;
            end
        end else begin
            hi = 32767;
            lo = -hi - 1;
            for (int i = 0; i < NH; i++) begin
                sa = longint'($signed(a[16*i +: 16]));
                sb = longint'($signed(b[16*i +: 16]));
                t  = o[1] ? (sb - sa) : (sa + sb);
                ov = (t > hi) || (t < lo);
                if (sat && ov) t = (t > hi) ? hi : lo;
                r[16*i +: 16] = t[15:0];
                f[i]          = ov;
            end
        end
    endfunction

    // Scoreboard: handshakes are sampled mid-cycle, where they equal what the next rising edge sees.
    always @(negedge clk) begin
        check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (exp_q.size() == 0) begin
            check("spurious_out_valid", bus.out_valid, 1'b0);
        end else if (bus.out_valid) begin
            check("sb_result", bus.result, exp_q[0].res);
            check("sb_tag", bus.tag_out, exp_q[0].tag);
            check("sb_ovf", bus.ovf, exp_q[0].ovf);
        end
        if (!rst_n) begin
            n_drop += exp_q.size();
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_pop++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.ra, bus.rb, bus.op, e.res, e.ovf);
                e.tag = bus.tag_in;
                exp_q.push_back(e);
                n_push++;
            end
        end
    end

    // Presents an op and returns 1 ns after the edge that accepted it; in_valid stays high.
    task automatic send(input logic [0:DATA_W-1] a, input logic [0:DATA_W-1] b,
                        input logic [2:0] o, input logic [TAG_W-1:0] t);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.ra       = a;
        bus.rb       = b;
        bus.op       = o;
        bus.tag_in   = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accepted", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("wait_out", ok, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:DATA_W-1] va [4];
        logic [0:DATA_W-1] vb [4];
        logic [2:0]        vo [4];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ra        = '0;
        bus.rb        = '0;
        bus.op        = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;

        // Pin the model against hand-computed values.
        model({8{16'hFFFF}}, {8{16'h0001}}, 3'b000, pr, pf);
        check("pin_model_hw_add", pr, 128'h0);
        check("pin_model_hw_add_ovf", pf, 8'h00);
        model({32'h0000_0001, 96'h0}, {32'h0, 32'h5, 64'h0}, 3'b011, pr, pf);
        check("pin_model_word_sub", pr, {32'hFFFF_FFFF, 32'h0000_0005, 64'h0});
        model({16'h7FFF, 112'h0}, {16'h0001, 112'h0}, 3'b100, pr, pf);
        check("pin_model_sat", pr, {SAT_HW_EXP, 112'h0});
        check("pin_model_sat_ovf", pf, 8'h80);

        // Reset, with an op presented during the last reset cycle.
        @(posedge clk); #1;
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_result", bus.result, 128'h0);
        check("reset_tag", bus.tag_out, 7'h0);
        check("reset_ovf", bus.ovf, 8'h0);
        bus.in_valid = 1'b1;
        bus.ra       = {8{16'h0101}};
        bus.rb       = {8{16'h0202}};
        bus.tag_in   = 7'h11;
        @(posedge clk); #1;
        check("reset_in_ready_2", bus.in_ready, 1'b1);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        repeat (STAGES + 1) begin
            @(posedge clk); #1;
            check("reset_op_discarded", bus.out_valid, 1'b0);
        end

        // Halfword wrap with exact latency.
        send({8{16'hFFFF}}, {8{16'h0001}}, 3'b000, 7'd1);
        bus.in_valid = 1'b0;
        repeat (STAGES - 1) begin
            check("latency_early", bus.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        check("latency_valid", bus.out_valid, 1'b1);
        check("hw_add_result", bus.result, 128'h0);
        check("hw_add_ovf", bus.ovf, 8'h00);
        check("hw_add_tag", bus.tag_out, 7'd1);
        drain();

        // Word subtract-from; neighbouring lane must be untouched by the borrow.
        send({32'h0000_0001, 96'h0}, {32'h0, 32'h5, 64'h0}, 3'b011, 7'd2);
        bus.in_valid = 1'b0;
        wait_out();
        check("word_sub_result", bus.result, {32'hFFFF_FFFF, 32'h0000_0005, 64'h0});
        check("word_sub_ovf", bus.ovf, 8'h00);
        drain();

        // Saturation select on a halfword overflow.
        send({16'h7FFF, 112'h0}, {16'h0001, 112'h0}, 3'b100, 7'd3);
        bus.in_valid = 1'b0;
        wait_out();
        check("sat_result", bus.result, {SAT_HW_EXP, 112'h0});
        check("sat_ovf", bus.ovf, 8'h80);
        drain();

        // Overflow corner vectors through the scoreboard.
        va[0] = {16'h0001, 16'h7FFF, 96'h0};       vb[0] = {16'h8000, 16'h8000, 96'h0};       vo[0] = 3'b010;
        va[1] = {32'h7FFF_FFFF, 32'h8000_0000, 64'h1}; vb[1] = {32'h1, 32'hFFFF_FFFF, 64'h2}; vo[1] = 3'b001;
        va[2] = va[1];                             vb[2] = vb[1];                             vo[2] = 3'b101;
        va[3] = {8{16'h8000}};                     vb[3] = {16'h8000, 16'h7FFF, 96'h0};       vo[3] = 3'b100;
        for (int i = 0; i < 4; i++) send(va[i], vb[i], vo[i], 7'(8 + i));
        bus.in_valid = 1'b0;
        drain();

        // Back-to-back: eight consecutive results in tag order.
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    send({4{32'h7FFF_0000 + 32'(t) * 32'h0101}}, {4{32'h0001_8000 - 32'(t)}}, 3'(t), 7'(t));
                end
                bus.in_valid = 1'b0;
            end
            begin
                wait_out();
                for (int i = 0; i < 8; i++) begin
                    check("b2b_valid", bus.out_valid, 1'b1);
                    check("b2b_tag", bus.tag_out, 7'(i));
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        // Backpressure with a full pipe.
        bus.out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 6; t++) begin
                    send({8{16'h4000 + 16'(t)}}, {8{16'h3FFF + 16'(t)}}, 3'(t), 7'h20 + 7'(t));
                end
                bus.in_valid = 1'b0;
            end
            begin
                wait_out();
                snap_res = bus.result;
                snap_tag = bus.tag_out;
                snap_ovf = bus.ovf;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("stall_in_ready", bus.in_ready, 1'b0);
                    check("stall_out_valid", bus.out_valid, 1'b1);
                    check("stall_result", bus.result, snap_res);
                    check("stall_tag", bus.tag_out, snap_tag);
                    check("stall_ovf", bus.ovf, snap_ovf);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight, then a fresh op.
        bus.out_ready = 1'b0;
        send({8{16'h1111}}, {8{16'h2222}}, 3'b000, 7'h30);
        send({8{16'h3333}}, {8{16'h4444}}, 3'b000, 7'h31);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (STAGES + 2) begin
            check("flush_no_out", bus.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        send({8{16'h1234}}, {8{16'h1111}}, 3'b000, 7'h55);
        bus.in_valid = 1'b0;
        wait_out();
        check("post_flush_result", bus.result, {8{16'h2345}});
        check("post_flush_tag", bus.tag_out, 7'h55);
        drain();

        check("sb_balance", n_pop + n_drop, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
